// File: rtl/code_lock_pkg.sv
// Shared definitions for the parametrised code lock: state encoding and code-width helper.
package code_lock_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ENTRY   = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_PROG    = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ENTRY   = ST_ENTRY,
    S_OPEN    = ST_OPEN,
    S_PROG    = ST_PROG,
    S_LOCKOUT = ST_LOCKOUT
  } state_t;

  // CODE_W = CODE_LEN * DIGIT_W
  function automatic int code_w(input int code_len, input int digit_w);
    return code_len * digit_w;
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module lockout_timer #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] LOAD  = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/code_lock_param.sv
// Parametrised keypad code lock with attempt limit, timed lockout and in-field reprogramming.
module code_lock_param
  import code_lock_pkg::*;
#(
  parameter int                          DIGIT_W      = 4,
  parameter int                          CODE_LEN     = 4,
  parameter int                          MAX_TRIES    = 3,
  parameter int                          LOCKOUT_CYC  = 16,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'hBFDC
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             digit_valid,
  input  logic [DIGIT_W-1:0]               digit,
  input  logic                             prog_en,
  output logic                             unlocked,
  output logic                             buzzer,
  output logic                             locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count,
  output logic [$clog2(CODE_LEN+1)-1:0]    digit_idx
);

  localparam int CODE_W = code_w(CODE_LEN, DIGIT_W);
  localparam int FW     = $clog2(MAX_TRIES + 1);
  localparam int IW     = $clog2(CODE_LEN + 1);
  localparam int TW     = $clog2(LOCKOUT_CYC);

  localparam logic [TW-1:0] T_LOAD    = TW'(LOCKOUT_CYC - 1);
  localparam logic [FW-1:0] TRIES_MAX = FW'(MAX_TRIES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(CODE_LEN - 1);
  localparam logic [IW-1:0] IDX_FULL  = IW'(CODE_LEN);

  state_t              state;
  logic [CODE_W-1:0]   code_q;
  logic [CODE_W-1:0]   stage_q;
  logic [CODE_W-1:0]   stage_nxt;
  logic                mis_q;
  logic [DIGIT_W-1:0]  slot;
  logic                mis_now;
  logic                last_dig;
  logic [FW-1:0]       fail_inc;
  logic                timer_load;
  logic                timer_en;
  logic                timer_exp;

  // Digit slot 0 is the most significant slice of the code word.
  always_comb begin
    slot      = '0;
    stage_nxt = stage_q;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (digit_idx == IW'(i)) begin
        slot = code_q[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
        stage_nxt[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit;
      end
    end
    mis_now    = mis_q | (digit != slot);
    last_dig   = (digit_idx == LAST_IDX);
    fail_inc   = (fail_count == TRIES_MAX) ? fail_count : fail_count + 1'b1;
    timer_load = (state == S_ENTRY) && !start && digit_valid && last_dig &&
                 mis_now && (fail_inc == TRIES_MAX);
    timer_en   = (state == S_LOCKOUT);
  end

  lockout_timer #(
    .WIDTH (TW),
    .LOAD  (T_LOAD)
  ) u_timer (
    .clk     (clk),
    .rst     (reset),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_exp)
  );

  // digit_idx shows CODE_LEN for the single cycle after a full pass, then clears in the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      code_q     <= DEFAULT_CODE;
      stage_q    <= '0;
      mis_q      <= 1'b0;
      unlocked   <= 1'b0;
      buzzer     <= 1'b0;
      locked_out <= 1'b0;
      fail_count <= '0;
      digit_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          buzzer    <= 1'b0;
          digit_idx <= '0;
          if (start) begin
            state <= S_ENTRY;
            mis_q <= 1'b0;
          end
        end
        S_ENTRY: begin
          if (start) begin
            digit_idx <= '0;
            mis_q     <= 1'b0;
          end else if (digit_valid) begin
            if (last_dig) begin
              digit_idx <= IDX_FULL;
              mis_q     <= 1'b0;
              if (!mis_now) begin
                state      <= S_OPEN;
                unlocked   <= 1'b1;
                fail_count <= '0;
              end else begin
                fail_count <= fail_inc;
                buzzer     <= 1'b1;
                if (fail_inc == TRIES_MAX) begin
                  state      <= S_LOCKOUT;
                  locked_out <= 1'b1;
                end else begin
                  state <= S_IDLE;
                end
              end
            end else begin
              digit_idx <= digit_idx + 1'b1;
              mis_q     <= mis_now;
            end
          end
        end
        S_OPEN: begin
          digit_idx <= '0;
          if (start) begin
            state    <= S_IDLE;
            unlocked <= 1'b0;
          end else if (prog_en) begin
            state    <= S_PROG;
            unlocked <= 1'b0;
          end
        end
        S_PROG: begin
          if (start) begin
            state     <= S_IDLE;
            digit_idx <= '0;
          end else if (digit_valid) begin
            stage_q <= stage_nxt;
            if (last_dig) begin
              code_q    <= stage_nxt;
              state     <= S_OPEN;
              unlocked  <= 1'b1;
              digit_idx <= IDX_FULL;
            end else begin
              digit_idx <= digit_idx + 1'b1;
            end
          end
        end
        S_LOCKOUT: begin
          digit_idx <= '0;
          if (timer_exp) begin
            state      <= S_IDLE;
            locked_out <= 1'b0;
            buzzer     <= 1'b0;
            fail_count <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock_param.sv
// Directed bench for code_lock_param at default parameters (code B,F,D,C).
module tb_code_lock_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'h0;
  logic       prog_en = 1'b0;
  logic       unlocked, buzzer, locked_out;
  logic [1:0] fail_count;
  logic [2:0] digit_idx;

  int n_cmp = 0;
  int n_bad = 0;

  code_lock_param dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .digit_valid (digit_valid),
    .digit       (digit),
    .prog_en     (prog_en),
    .unlocked    (unlocked),
    .buzzer      (buzzer),
    .locked_out  (locked_out),
    .fail_count  (fail_count),
    .digit_idx   (digit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       dv;
    logic [3:0] d;
    logic       pg;
    logic       unl;
    logic       buz;
    logic       lo;
    logic [1:0] fc;
    logic [2:0] idx;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, input logic dv, input logic [3:0] d, input logic pg,
                     input logic unl, input logic buz, input logic lo,
                     input logic [1:0] fc, input logic [2:0] idx);
    vec_t v;
    v.st = st; v.dv = dv; v.d = d; v.pg = pg;
    v.unl = unl; v.buz = buz; v.lo = lo; v.fc = fc; v.idx = idx;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic unl, input logic buz, input logic lo,
                           input logic [1:0] fc, input logic [2:0] idx);
    check({tag, ".unlocked"},   32'(unlocked),   32'(unl));
    check({tag, ".buzzer"},     32'(buzzer),     32'(buz));
    check({tag, ".locked_out"}, 32'(locked_out), 32'(lo));
    check({tag, ".fail_count"}, 32'(fail_count), 32'(fc));
    check({tag, ".digit_idx"},  32'(digit_idx),  32'(idx));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic dv, input logic [3:0] d, input logic pg);
    start = st; digit_valid = dv; digit = d; prog_en = pg;
    step();
    start = 1'b0; digit_valid = 1'b0; digit = 4'h0; prog_en = 1'b0;
  endtask

  task automatic enter(input logic [15:0] c);
    logic [15:0] cc;
    cc = c;
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, cc[15-4*i -: 4], 1'b0);
  endtask

  initial begin
    // Reset values
    #2 reset = 1'b1;
    #1 check_all("reset", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    step();

    // Correct entry, relock, wrong entry, restart mid-entry, start+digit collision
    add(1,0,4'h0,0, 0,0,0,2'd0,3'd0);
    add(0,1,4'hB,0, 0,0,0,2'd0,3'd1);
    add(0,1,4'hF,0, 0,0,0,2'd0,3'd2);
    add(0,1,4'hD,0, 0,0,0,2'd0,3'd3);
    add(0,1,4'hC,0, 1,0,0,2'd0,3'd4);
    add(0,0,4'h0,0, 1,0,0,2'd0,3'd0);
    add(1,0,4'h0,0, 0,0,0,2'd0,3'd0);
    add(1,0,4'h0,0, 0,0,0,2'd0,3'd0);
    add(0,1,4'hB,0, 0,0,0,2'd0,3'd1);
    add(0,1,4'h0,0, 0,0,0,2'd0,3'd2);
    add(0,1,4'hD,0, 0,0,0,2'd0,3'd3);
    add(0,1,4'hC,0, 0,1,0,2'd1,3'd4);
    add(0,0,4'h0,0, 0,0,0,2'd1,3'd0);
    add(0,1,4'hB,0, 0,0,0,2'd1,3'd0);
    add(1,0,4'h0,0, 0,0,0,2'd1,3'd0);
    add(0,1,4'hB,0, 0,0,0,2'd1,3'd1);
    add(0,1,4'hF,0, 0,0,0,2'd1,3'd2);
    add(1,0,4'h0,0, 0,0,0,2'd1,3'd0);
    add(0,1,4'hB,0, 0,0,0,2'd1,3'd1);
    add(0,1,4'hF,0, 0,0,0,2'd1,3'd2);
    add(0,1,4'hD,0, 0,0,0,2'd1,3'd3);
    add(0,1,4'hC,0, 1,0,0,2'd0,3'd4);
    add(1,0,4'h0,0, 0,0,0,2'd0,3'd0);
    add(1,0,4'h0,0, 0,0,0,2'd0,3'd0);
    add(0,1,4'hB,0, 0,0,0,2'd0,3'd1);
    add(1,1,4'hF,0, 0,0,0,2'd0,3'd0);
    add(0,1,4'hB,0, 0,0,0,2'd0,3'd1);
    add(0,1,4'hF,0, 0,0,0,2'd0,3'd2);
    add(0,1,4'hD,0, 0,0,0,2'd0,3'd3);
    add(0,1,4'hC,0, 1,0,0,2'd0,3'd4);
    add(1,0,4'h0,0, 0,0,0,2'd0,3'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].dv, tbl[i].d, tbl[i].pg);
      check_all($sformatf("vec%0d", i), tbl[i].unl, tbl[i].buz, tbl[i].lo, tbl[i].fc, tbl[i].idx);
    end

    // Three wrong entries -> 16-cycle lockout with inputs ignored
    enter(16'h0000);
    check("lk.fail1", 32'(fail_count), 32'd1);
    check("lk.buz1", 32'(buzzer), 32'd1);
    enter(16'h1234);
    check("lk.fail2", 32'(fail_count), 32'd2);
    check("lk.lo2", 32'(locked_out), 32'd0);
    enter(16'h0000);
    check_all("lk.enter", 1'b0, 1'b1, 1'b1, 2'd3, 3'd4);
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b1, 4'hB, 1'b1);
      if (i < 16) begin
        check($sformatf("lk.hold%0d.locked_out", i), 32'(locked_out), 32'd1);
        check($sformatf("lk.hold%0d.buzzer", i), 32'(buzzer), 32'd1);
      end else begin
        check_all("lk.exit", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
      end
    end
    enter(16'hBFDC);
    check("lk.after_unlock", 32'(unlocked), 32'd1);
    drive(1'b1, 1'b0, 4'h0, 1'b0);

    // Reprogramming, abort, start priority over prog_en
    enter(16'hBFDC);
    check("pg.open", 32'(unlocked), 32'd1);
    drive(1'b0, 1'b0, 4'h0, 1'b1);
    check_all("pg.enter", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
    drive(1'b0, 1'b1, 4'h1, 1'b0);
    drive(1'b0, 1'b1, 4'h2, 1'b0);
    drive(1'b0, 1'b1, 4'h3, 1'b0);
    check("pg.idx3", 32'(digit_idx), 32'd3);
    drive(1'b0, 1'b1, 4'h4, 1'b0);
    check_all("pg.commit", 1'b1, 1'b0, 1'b0, 2'd0, 3'd4);
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    enter(16'h1234);
    check("pg.new_code", 32'(unlocked), 32'd1);
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    enter(16'hBFDC);
    check_all("pg.old_code", 1'b0, 1'b1, 1'b0, 2'd1, 3'd4);
    enter(16'h1234);
    drive(1'b0, 1'b0, 4'h0, 1'b1);
    drive(1'b0, 1'b1, 4'h5, 1'b0);
    drive(1'b0, 1'b1, 4'h6, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    check_all("pg.abort", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
    enter(16'h1234);
    check("pg.unchanged", 32'(unlocked), 32'd1);
    drive(1'b1, 1'b0, 4'h0, 1'b1);
    check("pg.start_prio", 32'(unlocked), 32'd0);
    drive(1'b0, 1'b1, 4'h5, 1'b0);
    check("pg.idle_ignores", 32'(digit_idx), 32'd0);

    // Asynchronous reset mid-PROG restores the default code
    enter(16'h1234);
    drive(1'b0, 1'b0, 4'h0, 1'b1);
    drive(1'b0, 1'b1, 4'h7, 1'b0);
    drive(1'b0, 1'b1, 4'h7, 1'b0);
    check("rp.idx_before", 32'(digit_idx), 32'd2);
    #3 reset = 1'b1;
    #1 check_all("rp.async", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
    #2 reset = 1'b0;
    step();
    enter(16'hBFDC);
    check("rp.default_code", 32'(unlocked), 32'd1);
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    enter(16'h1234);
    check("rp.prog_lost", 32'(fail_count), 32'd1);

    // Asynchronous reset mid-LOCKOUT
    enter(16'h1234);
    enter(16'h1234);
    step();
    step();
    check("rl.locked", 32'(locked_out), 32'd1);
    #3 reset = 1'b1;
    #1 check_all("rl.async", 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
    #2 reset = 1'b0;
    step();
    enter(16'hBFDC);
    check_all("rl.unlock", 1'b1, 1'b0, 1'b0, 2'd0, 3'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
